// File: rtl/mul_p3.sv
// mul_p3: final stage of the binary32 multiplier pipeline.
// Stage N normalizes the 48-bit significand product to a 23-bit fraction
// plus guard/sticky bits. Stage R rounds to nearest-even, resolves
// zero / flush-to-zero / overflow in priority order and packs the result.
// A sticky register ORs together the exception flags of every valid result
// since the last clear.
module mul_p3 #(
    parameter int EXP_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        sign_in,
    input  logic [8:0]  exp_sum_in,
    input  logic [47:0] mant_prod_in,
    input  logic        flags_clr,
    output logic        valid_out,
    output logic [31:0] result_out,
    output logic [2:0]  flags_out,
    output logic [2:0]  flags_sticky
);

    localparam logic [9:0] LP_EXP_MAX = 10'(EXP_MAX);

    // Normalize-stage combinational values
    logic        w_top;
    logic [22:0] w_n_mant;
    logic        w_n_g;
    logic        w_n_s;
    logic [9:0]  w_n_exp;
    logic        w_n_zero;

    // Normalize-stage registers
    logic        r_n_valid;
    logic        r_n_sign;
    logic [9:0]  r_n_exp;
    logic [22:0] r_n_mant;
    logic        r_n_g;
    logic        r_n_s;
    logic        r_n_zero;

    // Round-stage combinational values
    logic        w_round_up;
    logic [23:0] w_mant_sum;
    logic [9:0]  w_exp_r;
    logic [31:0] w_result;
    logic [2:0]  w_flags;

    // Output registers
    logic        r_valid_out;
    logic [31:0] r_result;
    logic [2:0]  r_flags;
    logic [2:0]  r_sticky;

    // A product of two [1,2) significands lies in [1,4): bit 47 tells
    // whether one extra position of normalization shift is needed.
    always_comb begin
        w_top    = mant_prod_in[47];
        w_n_mant = '0;
        w_n_g    = 1'b0;
        w_n_s    = 1'b0;
        w_n_exp  = {1'b0, exp_sum_in};
        w_n_zero = (mant_prod_in == 48'd0);
        if (w_top) begin
            w_n_mant = mant_prod_in[46:24];
            w_n_g    = mant_prod_in[23];
            w_n_s    = |mant_prod_in[22:0];
            w_n_exp  = {1'b0, exp_sum_in} + 10'd1;
        end else begin
            w_n_mant = mant_prod_in[45:23];
            w_n_g    = mant_prod_in[22];
            w_n_s    = |mant_prod_in[21:0];
        end
    end

    // Normalize register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_valid <= 1'b0;
            r_n_sign  <= 1'b0;
            r_n_exp   <= '0;
            r_n_mant  <= '0;
            r_n_g     <= 1'b0;
            r_n_s     <= 1'b0;
            r_n_zero  <= 1'b0;
        end else begin
            r_n_valid <= valid_in;
            r_n_sign  <= sign_in;
            r_n_exp   <= w_n_exp;
            r_n_mant  <= w_n_mant;
            r_n_g     <= w_n_g;
            r_n_s     <= w_n_s;
            r_n_zero  <= w_n_zero;
        end
    end

    // Round-to-nearest-even; a carry out of the fraction leaves it all
    // zeros and bumps the exponent (significand becomes exactly 2.0).
    assign w_round_up = r_n_g & (r_n_s | r_n_mant[0]);
    assign w_mant_sum = {1'b0, r_n_mant} + {23'd0, w_round_up};
    assign w_exp_r    = r_n_exp + {9'd0, w_mant_sum[23]};

    // Result selection in priority order: zero, flush-to-zero, overflow, normal
    always_comb begin
        w_result = {r_n_sign, 31'd0};
        w_flags  = 3'b000;
        if (r_n_zero) begin
            w_result = {r_n_sign, 31'd0};
            w_flags  = 3'b000;
        end else if (r_n_exp == 10'd0) begin
            w_result = {r_n_sign, 31'd0};
            w_flags  = 3'b011;
        end else if (w_exp_r >= LP_EXP_MAX) begin
            w_result = {r_n_sign, 8'hFF, 23'd0};
            w_flags  = 3'b101;
        end else begin
            w_result = {r_n_sign, w_exp_r[7:0], w_mant_sum[22:0]};
            w_flags  = {2'b00, r_n_g | r_n_s};
        end
    end

    // Round/pack register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            r_valid_out <= r_n_valid;
            r_result    <= w_result;
            r_flags     <= w_flags;
        end
    end

    // Sticky accumulator: a clear coinciding with a valid result keeps
    // only that result's flags, bubbles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (flags_clr) begin
            r_sticky <= r_valid_out ? r_flags : 3'b000;
        end else if (r_valid_out) begin
            r_sticky <= r_sticky | r_flags;
        end
    end

    assign valid_out    = r_valid_out;
    assign result_out   = r_result;
    assign flags_out    = r_flags;
    assign flags_sticky = r_sticky;

endmodule

// File: tb/tb_mul_p3.sv
// Testbench for mul_p3: directed vectors with hand-derived expectations
// plus randomized significand products checked against an arithmetic
// reference of IEEE round-to-nearest-even multiplication.
module tb_mul_p3;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        sign_in;
    logic [8:0]  exp_sum_in;
    logic [47:0] mant_prod_in;
    logic        flags_clr;
    logic        valid_out;
    logic [31:0] result_out;
    logic [2:0]  flags_out;
    logic [2:0]  flags_sticky;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    exp_t       pipe [2];
    exp_t       cur;
    logic [2:0] model_sticky;

    mul_p3 #(.EXP_MAX(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .sign_in      (sign_in),
        .exp_sum_in   (exp_sum_in),
        .mant_prod_in (mant_prod_in),
        .flags_clr    (flags_clr),
        .valid_out    (valid_out),
        .result_out   (result_out),
        .flags_out    (flags_out),
        .flags_sticky (flags_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: value = p * 2^(e-127-46); round the significand to 24 bits
    // with round-half-even, then classify. Returns {flags, result}.
    function automatic logic [34:0] ref_mul(input logic s, input logic [8:0] e, input logic [47:0] p);
        logic [63:0] m, rem, half;
        int          sh;
        int          ee;
        logic        ru;
        logic        inexact;
        if (p == 48'd0) return {3'b000, s, 31'd0};
        sh = p[47] ? 24 : 23;
        ee = int'(e) + (p[47] ? 1 : 0);
        if (ee == 0) return {3'b011, s, 31'd0};
        m    = {16'd0, p} >> sh;
        rem  = {16'd0, p} - (m << sh);
        half = 64'd1 << (sh - 1);
        ru   = (rem > half) || ((rem == half) && m[0]);
        inexact = (rem != 64'd0);
        m = m + {63'd0, ru};
        if (m == (64'd1 << 24)) begin
            m  = m >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) return {3'b101, s, 8'hFF, 23'd0};
        return {2'b00, inexact, s, 8'(ee), m[22:0]};
    endfunction

    // Output monitor: results appear two edges after their inputs are applied.
    always @(negedge clk) begin
        if (rst) begin
            check_val("rst_valid", {31'd0, valid_out}, 32'd0);
            check_val("rst_result", result_out, 32'd0);
            check_val("rst_flags", {29'd0, flags_out}, 32'd0);
            check_val("rst_sticky", {29'd0, flags_sticky}, 32'd0);
            pipe[0].v = 1'b0;
            pipe[1].v = 1'b0;
            model_sticky = 3'b000;
        end else begin
            check_val("valid_out", {31'd0, valid_out}, {31'd0, pipe[1].v});
            if (pipe[1].v) begin
                n_txn++;
                $display("txn %0d result=%h flags=%b (exp %h %b) sticky=%b", n_txn, result_out,
                         flags_out, pipe[1].res, pipe[1].fl, flags_sticky);
                check_val("result", result_out, pipe[1].res);
                check_val("flags", {29'd0, flags_out}, {29'd0, pipe[1].fl});
            end
            check_val("sticky", {29'd0, flags_sticky}, {29'd0, model_sticky});
            if (flags_clr) model_sticky = pipe[1].v ? pipe[1].fl : 3'b000;
            else if (pipe[1].v) model_sticky = model_sticky | pipe[1].fl;
            pipe[1] = pipe[0];
            pipe[0] = cur;
        end
    end

    // Apply one cycle of input with a given expected outcome
    task automatic drive(input logic v, input logic s, input logic [8:0] e, input logic [47:0] p,
                         input logic clr, input logic [31:0] xres, input logic [2:0] xfl);
        @(posedge clk);
        #1;
        valid_in     = v;
        sign_in      = s;
        exp_sum_in   = e;
        mant_prod_in = p;
        flags_clr    = clr;
        cur.v   = v;
        cur.res = xres;
        cur.fl  = xfl;
    endtask

    task automatic bubble(input logic clr);
        drive(1'b0, 1'b0, 9'd0, 48'd0, clr, 32'd0, 3'b000);
    endtask

    task automatic send_rand(input logic clr);
        logic [23:0] a, b;
        logic [47:0] p;
        logic [8:0]  e;
        logic        s;
        logic [34:0] r;
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        case ($urandom_range(0, 7))
            0:       a[22:0] = 23'h7FFFFF;
            1:       b[22:0] = 23'd0;
            default: ;
        endcase
        p = 48'(a) * 48'(b);
        if ($urandom_range(0, 15) == 0) p = 48'd0;
        if ($urandom_range(0, 1) == 0) e = 9'($urandom_range(0, 511));
        else e = 9'($urandom_range(0, 3) == 0 ? $urandom_range(250, 256) : $urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0) e = 9'($urandom_range(100, 160));
        s = 1'($urandom);
        r = ref_mul(s, e, p);
        drive(1'b1, s, e, p, clr, r[31:0], r[34:32]);
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        sign_in = 1'b0;
        exp_sum_in = '0;
        mant_prod_in = '0;
        flags_clr = 1'b0;
        cur = '{v: 1'b0, res: 32'd0, fl: 3'b000};
        pipe[0] = cur;
        pipe[1] = cur;
        model_sticky = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bubble(1'b0);

        // Directed vectors
        drive(1'b1, 1'b0, 9'd127, 48'h900000000000, 1'b0, 32'h40100000, 3'b000);
        drive(1'b1, 1'b1, 9'd127, 48'h400000000000, 1'b0, 32'hBF800000, 3'b000);
        drive(1'b1, 1'b0, 9'd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b001);
        drive(1'b1, 1'b0, 9'd127, 48'h400000C00000, 1'b0, 32'h3F800002, 3'b001);
        drive(1'b1, 1'b0, 9'd127, 48'h7FFFFFC00000, 1'b0, 32'h40000000, 3'b001);
        drive(1'b1, 1'b0, 9'd254, 48'h800000000000, 1'b0, 32'h7F800000, 3'b101);
        drive(1'b1, 1'b1, 9'd0,   48'h400000000000, 1'b0, 32'h80000000, 3'b011);
        drive(1'b1, 1'b1, 9'd0,   48'h000000000000, 1'b0, 32'h80000000, 3'b000);
        bubble(1'b0);
        bubble(1'b0);
        bubble(1'b0);

        // Clear coinciding with a valid result whose flags are 001
        drive(1'b1, 1'b0, 9'd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b001);
        bubble(1'b0);
        bubble(1'b1);
        bubble(1'b0);
        bubble(1'b0);
        // Clear alone
        bubble(1'b1);
        bubble(1'b0);

        // Four back-to-back random ops then bubbles
        repeat (4) send_rand(1'b0);
        repeat (3) bubble(1'b0);

        // Reset one cycle after a valid op: in-flight work must vanish
        drive(1'b1, 1'b0, 9'd254, 48'h800000000000, 1'b0, 32'h7F800000, 3'b101);
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_in = 1'b0;
        cur.v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) bubble(1'b0);

        // Randomized traffic with random bubbles and clears
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) bubble($urandom_range(0, 7) == 0);
            else send_rand($urandom_range(0, 9) == 0);
        end
        repeat (4) bubble(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
